pipeline_3_memaccess: RTL and testbench
=======================================

Name: pipeline_3_memaccess

Overview:
Memory-access stage of the 5-stage pipeline, between execute (stage 2) and register writeback (stage 4). Registers the execute-stage outputs and drives the synchronous data RAM with a 1-cycle registered read. Routes accesses at or above IO_BASE to a req/ack peripheral bus with timeout, stalling upstream while the access is in flight. Supplies writeback with control, ALU result and load data aligned to the RAM output register.

Parameters:
IO_BASE, 16'hFF00, first address decoded as I/O; addresses below go to RAM
TIMEOUT, 255, max cycles in IO_WAIT before the access is aborted
CNT_W, 8, width of the timeout counter; must hold TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
control_in  in  22  decoded control from execute; [21:19] opcode, [3] reg write, [2:0] dest reg
result_in  in  16  ALU result / effective address
store_data_in  in  16  STR source data
flush_in  in  1  sync flush from delayed-branch taken (high = kill the instruction held here)
ram_rdata_in  in  16  registered RAM output (valid the cycle after the address)
io_ack_in  in  1  peripheral completion, 1-cycle pulse
io_rdata_in  in  16  peripheral read data, valid with io_ack_in
control_out  out  22  control to writeback stage regs
result_out  out  16  result to writeback stage regs
rdata_out  out  16  load data to writeback, valid one cycle after control_out carried the load
stall_out  out  1  high = upstream must hold its outputs
ram_addr_out  out  16  RAM address
ram_wdata_out  out  16  RAM write data
ram_we_out  out  1  RAM write enable
io_req_out  out  1  peripheral request, level
io_addr_out  out  8  result_q[7:0]
io_wdata_out  out  16  store_q
io_we_out  out  1  1 = peripheral write, 0 = read; valid while io_req_out
io_err_out  out  1  sticky timeout flag

Behaviour:
- Stage regs control_q, result_q, store_q load from inputs on each edge when stall_out=0. When flush_in=1 and stall_out=0, control_q loads 0 (bubble). Bubble = control 22'b0.
- Opcodes: 011 LDR, 100 STR; others are pass-through. is_mem = LDR|STR; is_io = is_mem & (result_q >= IO_BASE).
- ram_addr_out=result_q, ram_wdata_out=store_q, combinational. ram_we_out = STR & !is_io & state==RUN & !flush_in.
- FSM states: RUN, IO_WAIT, IO_DONE.
  - RUN: if is_io & !flush_in, go to IO_WAIT; otherwise stay.
  - IO_WAIT: io_req_out=1, stall_out=1, control_out=bubble, count increments. io_ack_in captures io_rdata_in into io_data_q and goes to IO_DONE. count==TIMEOUT with no ack: drop req, set io_err, io_data_q=16'hFFFF, go to IO_DONE. An ack arriving in the same cycle as the timeout wins.
  - IO_DONE: one cycle, stall_out=0, control_out=control_q (or bubble if flushed_q), then RUN.
- In RUN, control_out/result_out = control_q/result_q. stall_out=0 except in IO_WAIT.
- Entering IO_WAIT from RUN: control_out=bubble in that cycle, stall_out=1 combinationally (is_io in RUN also asserts stall), io_req_out asserted from the same cycle.
- flush_in during IO_WAIT does not abort the bus access. flushed_q is set; req is held to ack/timeout; IO_DONE emits bubble.
- sel_io_q <= (state==IO_DONE). rdata_out = sel_io_q ? io_data_q : ram_rdata_in.
- io_err_out is sticky until reset.
- Reset (async, rst=0): control_q=0, result_q=0, store_q=0, state=RUN, count=0, io_data_q=0, sel_io_q=0, flushed_q=0, io_err=0. All outputs therefore reset to 0.
- Reset mid IO_WAIT abandons the access immediately (req drops).
- Back-to-back I/O: the second access enters IO_WAIT the cycle after IO_DONE.

Test Plan:
- LDR r2, addr 0x0010, RAM[0x10]=0xBEEF -> ram_addr_out=0x0010 at cycle k, control_out[3:0]=4'b1010 at k, rdata_out=0xBEEF at k+1, stall_out never high.
- STR to 0x0020 data 0x1234 -> ram_we_out=1 for exactly 1 cycle, ram_wdata_out=0x1234, io_req_out=0.
- LDR from 0xFF04, ack after 3 cycles with 0x00A5 -> io_addr_out=0x04, stall_out high 4 cycles, control_out bubble during IO_WAIT, LDR emitted in IO_DONE, rdata_out=0x00A5 next cycle.
- I/O read with no ack, TIMEOUT=255 -> io_req_out drops after 256 cycles in IO_WAIT, io_err_out=1 and stays 1, rdata_out=0xFFFF.
- flush_in pulse while in IO_WAIT, then ack -> IO_DONE emits control_out=0; flush_in in RUN on an STR -> ram_we_out=0.
- rst low mid-IO_WAIT -> all outputs 0 asynchronously, state RUN; a subsequent RAM LDR completes normally.

Source files
------------

// File: rtl/pipeline_3_memaccess_if.sv
// ----------------------------------------------------------------------------
// pipeline_3_memaccess_if
//
// Memory-side buses of the memory-access pipeline stage, grouped so the stage
// sees them as one port.
//
//   RAM bus (synchronous data RAM, 1-cycle registered read)
//     ram_addr_out   16  address, stage -> RAM
//     ram_wdata_out  16  write data, stage -> RAM
//     ram_we_out      1  write enable, stage -> RAM
//     ram_rdata_in   16  registered read data, RAM -> stage
//
//   Peripheral bus (level request, 1-cycle ack pulse)
//     io_req_out      1  request, held until ack or timeout
//     io_addr_out     8  peripheral register address
//     io_wdata_out   16  write data
//     io_we_out       1  1 = write, 0 = read; valid while io_req_out
//     io_ack_in       1  completion pulse, peripheral -> stage
//     io_rdata_in    16  read data, valid with io_ack_in
//
// Modports: master = the pipeline stage, slave = the RAM / peripheral side.
// ----------------------------------------------------------------------------
interface pipeline_3_memaccess_if;

    logic [15:0] ram_addr_out;
    logic [15:0] ram_wdata_out;
    logic        ram_we_out;
    logic [15:0] ram_rdata_in;

    logic        io_req_out;
    logic [7:0]  io_addr_out;
    logic [15:0] io_wdata_out;
    logic        io_we_out;
    logic        io_ack_in;
    logic [15:0] io_rdata_in;

    modport master (
        output ram_addr_out,
        output ram_wdata_out,
        output ram_we_out,
        input  ram_rdata_in,
        output io_req_out,
        output io_addr_out,
        output io_wdata_out,
        output io_we_out,
        input  io_ack_in,
        input  io_rdata_in
    );

    modport slave (
        input  ram_addr_out,
        input  ram_wdata_out,
        input  ram_we_out,
        output ram_rdata_in,
        input  io_req_out,
        input  io_addr_out,
        input  io_wdata_out,
        input  io_we_out,
        output io_ack_in,
        output io_rdata_in
    );

endinterface

// File: rtl/pipeline_3_memaccess.sv
// ----------------------------------------------------------------------------
// pipeline_3_memaccess
//
// Memory-access stage of the 5-stage pipeline, sitting between execute and
// register writeback. It registers the execute outputs, drives the
// synchronous data RAM (registered read, data arrives one cycle after the
// address), and sends accesses at or above IO_BASE to a req/ack peripheral
// bus guarded by a timeout. While a peripheral access is in flight the stage
// stalls upstream and emits bubbles to writeback.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active-low
//   control_in     22  decoded control: [21:19] opcode, [3] reg write, [2:0] dest
//   result_in      16  ALU result / effective address
//   store_data_in  16  STR source data
//   flush_in        1  kill the instruction held here (delayed-branch taken)
//   control_out    22  control to writeback (22'b0 = bubble)
//   result_out     16  result to writeback
//   rdata_out      16  load data, valid one cycle after control_out carried it
//   stall_out       1  upstream must hold its outputs
//   io_err_out      1  sticky peripheral timeout flag
//   bus                RAM and peripheral buses (master side)
//
// Opcodes: 011 = LDR, 100 = STR, everything else passes straight through.
// ----------------------------------------------------------------------------
module pipeline_3_memaccess #(
    parameter logic [15:0] IO_BASE = 16'hFF00,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [21:0]                   control_in,
    input  logic [15:0]                   result_in,
    input  logic [15:0]                   store_data_in,
    input  logic                          flush_in,

    output logic [21:0]                   control_out,
    output logic [15:0]                   result_out,
    output logic [15:0]                   rdata_out,
    output logic                          stall_out,
    output logic                          io_err_out,

    pipeline_3_memaccess_if.master        bus
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    localparam logic [2:0]       OpLdr      = 3'b011;
    localparam logic [2:0]       OpStr      = 3'b100;
    localparam logic [21:0]      Bubble     = 22'b0;
    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        StRun,
        StIoWait,
        StIoDone
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [21:0]      control_q;
    logic [15:0]      result_q;
    logic [15:0]      store_q;

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [15:0]      io_data_q, io_data_d;
    logic             io_err_q,  io_err_d;
    logic             flushed_q, flushed_d;
    logic             sel_io_q;

    // ------------------------------------------------------------------------
    // Decode of the instruction held in the stage registers
    // ------------------------------------------------------------------------
    logic [2:0] opcode;
    logic       is_ldr;
    logic       is_str;
    logic       is_mem;
    logic       is_io;

    assign opcode = control_q[21:19];
    assign is_ldr = (opcode == OpLdr);
    assign is_str = (opcode == OpStr);
    assign is_mem = is_ldr | is_str;
    assign is_io  = is_mem & (result_q >= IO_BASE);

    // ------------------------------------------------------------------------
    // Stage registers: hold while stalled, load a bubble on flush
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            control_q <= Bubble;
            result_q  <= '0;
            store_q   <= '0;
        end else if (!stall_out) begin
            control_q <= flush_in ? Bubble : control_in;
            result_q  <= result_in;
            store_q   <= store_data_in;
        end
    end

    // ------------------------------------------------------------------------
    // Peripheral access FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StRun;
            count_q   <= '0;
            io_data_q <= '0;
            io_err_q  <= 1'b0;
            flushed_q <= 1'b0;
            sel_io_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            io_data_q <= io_data_d;
            io_err_q  <= io_err_d;
            flushed_q <= flushed_d;
            // Steers the load-data mux in the cycle after IO_DONE, which is
            // when writeback expects the data of the load emitted in IO_DONE.
            sel_io_q  <= (state_q == StIoDone);
        end
    end

    // ------------------------------------------------------------------------
    // Peripheral access FSM: next state and stage outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        io_data_d      = io_data_q;
        io_err_d       = io_err_q;
        flushed_d      = 1'b0;
        stall_out      = 1'b0;
        bus.io_req_out = 1'b0;
        control_out    = control_q;

        unique case (state_q)
            StRun: begin
                count_d = '0;
                // A flushed I/O instruction is simply dropped; the stage keeps
                // flowing so the bubble loads on this edge.
                if (is_io && !flush_in) begin
                    state_d        = StIoWait;
                    stall_out      = 1'b1;
                    bus.io_req_out = 1'b1;
                    control_out    = Bubble;
                end
            end

            StIoWait: begin
                stall_out      = 1'b1;
                bus.io_req_out = 1'b1;
                control_out    = Bubble;
                count_d        = count_q + 1'b1;
                // The bus access cannot be cancelled once started; a flush is
                // remembered and turns the eventual emission into a bubble.
                flushed_d      = flushed_q | flush_in;
                if (bus.io_ack_in) begin
                    // Ack wins over a timeout landing in the same cycle.
                    io_data_d = bus.io_rdata_in;
                    state_d   = StIoDone;
                end else if (count_q == TimeoutCnt) begin
                    io_err_d  = 1'b1;
                    io_data_d = 16'hFFFF;
                    state_d   = StIoDone;
                end
            end

            StIoDone: begin
                count_d     = '0;
                control_out = flushed_q ? Bubble : control_q;
                state_d     = StRun;
            end

            default: begin
                state_d = StRun;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // RAM and peripheral bus drive
    // ------------------------------------------------------------------------
    assign bus.ram_addr_out  = result_q;
    assign bus.ram_wdata_out = store_q;
    assign bus.ram_we_out    = is_str & ~is_io & (state_q == StRun) & ~flush_in;

    assign bus.io_addr_out   = result_q[7:0];
    assign bus.io_wdata_out  = store_q;
    assign bus.io_we_out     = is_str;

    // ------------------------------------------------------------------------
    // Writeback outputs
    // ------------------------------------------------------------------------
    assign result_out = result_q;
    assign rdata_out  = sel_io_q ? io_data_q : bus.ram_rdata_in;
    assign io_err_out = io_err_q;

endmodule

// File: tb/tb_pipeline_3_memaccess.sv
// ----------------------------------------------------------------------------
// tb_pipeline_3_memaccess
//
// Bench for the memory-access stage: a vector table for single-instruction
// RAM behaviour, hand-written sequences for peripheral access, timeout,
// flush-during-wait and reset-during-wait, and a randomized instruction
// stream checked against an in-order memory/peripheral reference model.
// ----------------------------------------------------------------------------
module tb_pipeline_3_memaccess;

    localparam logic [15:0] IoBase = 16'hFF00;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [21:0] control_in;
    logic [15:0] result_in;
    logic [15:0] store_data_in;
    logic        flush_in;
    logic [21:0] control_out;
    logic [15:0] result_out;
    logic [15:0] rdata_out;
    logic        stall_out;
    logic        io_err_out;

    pipeline_3_memaccess_if bus ();

    pipeline_3_memaccess #(
        .IO_BASE (16'hFF00),
        .TIMEOUT (255),
        .CNT_W   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .control_in    (control_in),
        .result_in     (result_in),
        .store_data_in (store_data_in),
        .flush_in      (flush_in),
        .control_out   (control_out),
        .result_out    (result_out),
        .rdata_out     (rdata_out),
        .stall_out     (stall_out),
        .io_err_out    (io_err_out),
        .bus           (bus)
    );

    // ------------------------------------------------------------------------
    // Initial memory contents
    // ------------------------------------------------------------------------
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    function automatic logic [15:0] io_init(input logic [7:0] a);
        return {8'hC3, a};
    endfunction

    function automatic logic [21:0] mk(input logic [2:0] op, input logic [14:0] mid,
                                       input logic [3:0] lo);
        return {op, mid, lo};
    endfunction

    // ------------------------------------------------------------------------
    // RAM with registered read, and peripheral register file
    // ------------------------------------------------------------------------
    logic [15:0] ram [65536];
    logic [15:0] ram_q;
    logic [15:0] periph [256];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_q <= '0;
            for (int i = 0; i < 65536; i++) ram[i] <= init_val(16'(i));
            for (int i = 0; i < 256; i++) periph[i] <= io_init(8'(i));
        end else begin
            if (bus.ram_we_out) ram[bus.ram_addr_out] <= bus.ram_wdata_out;
            ram_q <= ram[bus.ram_addr_out];
            if (bus.io_ack_in && bus.io_req_out && bus.io_we_out)
                periph[bus.io_addr_out] <= bus.io_wdata_out;
        end
    end
    assign bus.ram_rdata_in = ram_q;

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model for the random stream: instructions leave in order,
    // RAM and peripheral space are plain arrays updated when a store leaves.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [21:0] ctrl;
        logic [15:0] res;
        logic [15:0] st;
    } instr_t;

    instr_t      exp_q[$];
    instr_t      cur;
    bit          need_new;
    int          req_seen;
    int          ack_delay;
    bit          pend;
    logic [15:0] pend_val;
    logic [15:0] model_mem [65536];
    logic [15:0] model_io  [256];

    function automatic instr_t gen_instr();
        instr_t      t;
        int unsigned r;
        logic [2:0]  op;
        logic [2:0]  others [6];
        others = '{3'b000, 3'b001, 3'b010, 3'b101, 3'b110, 3'b111};
        r = $urandom_range(0, 9);
        if (r < 4)      op = 3'b011;
        else if (r < 7) op = 3'b100;
        else            op = others[$urandom_range(0, 5)];
        t.ctrl = mk(op, 15'($urandom), 4'($urandom)) | 22'h000400;
        if ($urandom_range(0, 3) == 0) t.res = IoBase | 16'($urandom_range(0, 7));
        else                           t.res = 16'($urandom_range(0, 31));
        t.st = 16'($urandom);
        if ($urandom_range(0, 9) == 0) t.ctrl = '0;
        return t;
    endfunction

    task automatic rand_cycle(input bit gen);
        instr_t     e;
        logic [2:0] op;
        @(negedge clk);
        bus.io_ack_in = 1'b0;
        if (need_new) begin
            if (gen) cur = gen_instr();
            else     cur = '{ctrl: '0, res: '0, st: '0};
        end
        control_in    = cur.ctrl;
        result_in     = cur.res;
        store_data_in = cur.st;
        #1;
        // Peripheral: ack after a random number of request cycles.
        if (bus.io_req_out) begin
            req_seen++;
            if (req_seen == ack_delay) begin
                bus.io_ack_in   = 1'b1;
                bus.io_rdata_in = periph[bus.io_addr_out];
            end
        end else begin
            req_seen  = 0;
            ack_delay = $urandom_range(2, 6);
        end
        #1;
        if (pend) begin
            check("rnd_rdata", rdata_out, pend_val);
            pend = 1'b0;
        end
        if (control_out != '0) begin
            if (exp_q.size() == 0) begin
                check("rnd_unexpected_emit", control_out, 0);
            end else begin
                e = exp_q.pop_front();
                check("rnd_ctrl", control_out, e.ctrl);
                check("rnd_result", result_out, e.res);
                op = e.ctrl[21:19];
                if (op == 3'b011) begin
                    pend     = 1'b1;
                    pend_val = (e.res >= IoBase) ? model_io[e.res[7:0]] : model_mem[e.res];
                end else if (op == 3'b100) begin
                    if (e.res >= IoBase) model_io[e.res[7:0]] = e.st;
                    else                 model_mem[e.res]     = e.st;
                end
            end
        end
        need_new = !stall_out;
        if (!stall_out && cur.ctrl != '0) exp_q.push_back(cur);
    endtask

    // ------------------------------------------------------------------------
    // Vector table: one RAM-side instruction each
    // ------------------------------------------------------------------------
    typedef struct {
        logic [21:0] ctrl;
        logic [15:0] res;
        logic [15:0] st;
        logic        flush;
        logic        chk_ctrl;
        logic        exp_we;
        logic        chk_rd;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    localparam int NumVec = 10;

    initial begin
        logic [21:0] c_ldr4;
        logic [21:0] c_ldr7;
        logic [21:0] c_strio;
        logic [21:0] c_ldr2;
        int          n_stall;
        int          req_cycles;
        bit          done;
        bit          bad_wait;

        control_in      = '0;
        result_in       = '0;
        store_data_in   = '0;
        flush_in        = 1'b0;
        bus.io_ack_in   = 1'b0;
        bus.io_rdata_in = '0;

        c_ldr2  = mk(3'b011, 15'h0000, 4'b1010);
        c_ldr4  = mk(3'b011, 15'h0000, 4'b1100);
        c_ldr7  = mk(3'b011, 15'h0000, 4'b1111);
        c_strio = mk(3'b100, 15'h0042, 4'b0000);

        vecs[0] = '{c_ldr2, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF};
        vecs[1] = '{mk(3'b100, 15'h0000, 4'b0000), 16'h0020, 16'h1234,
                    1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{mk(3'b011, 15'h0000, 4'b1101), 16'h0020, 16'h0000,
                    1'b0, 1'b1, 1'b0, 1'b1, 16'h1234};
        vecs[3] = '{mk(3'b000, 15'h0123, 4'b1011), 16'hFF10, 16'h5555,
                    1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{mk(3'b111, 15'h0000, 4'b0001), 16'h0030, 16'h9999,
                    1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};
        vecs[5] = '{mk(3'b011, 15'h0000, 4'b1001), 16'hFEFF, 16'h0000,
                    1'b0, 1'b1, 1'b0, 1'b1, init_val(16'hFEFF)};
        vecs[6] = '{mk(3'b100, 15'h0000, 4'b0000), 16'h0040, 16'hAAAA,
                    1'b1, 1'b0, 1'b0, 1'b0, 16'h0000};
        vecs[7] = '{mk(3'b011, 15'h0000, 4'b1110), 16'h0040, 16'h0000,
                    1'b0, 1'b1, 1'b0, 1'b1, init_val(16'h0040)};
        vecs[8] = '{mk(3'b100, 15'h0001, 4'b0000), 16'hFEFF, 16'h4321,
                    1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[9] = '{mk(3'b011, 15'h0000, 4'b1011), 16'hFEFF, 16'h0000,
                    1'b0, 1'b1, 1'b0, 1'b1, 16'h4321};

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctrl", control_out, 0);
        check("rst_result", result_out, 0);
        check("rst_rdata", rdata_out, 0);
        check("rst_stall", stall_out, 0);
        check("rst_req", bus.io_req_out, 0);
        check("rst_we", bus.ram_we_out, 0);
        check("rst_err", io_err_out, 0);
        @(negedge clk);
        rst = 1'b1;

        // ---------------- vector table ----------------
        for (int i = 0; i < NumVec; i++) begin
            @(negedge clk);
            control_in    = vecs[i].ctrl;
            result_in     = vecs[i].res;
            store_data_in = vecs[i].st;
            flush_in      = 1'b0;
            @(negedge clk);
            control_in    = '0;
            result_in     = '0;
            store_data_in = '0;
            flush_in      = vecs[i].flush;
            #1;
            if (vecs[i].chk_ctrl) check($sformatf("v%0d_ctrl", i), control_out, vecs[i].ctrl);
            check($sformatf("v%0d_we", i), bus.ram_we_out, vecs[i].exp_we);
            check($sformatf("v%0d_addr", i), bus.ram_addr_out, vecs[i].res);
            check($sformatf("v%0d_wdata", i), bus.ram_wdata_out, vecs[i].st);
            check($sformatf("v%0d_stall", i), stall_out, 0);
            check($sformatf("v%0d_req", i), bus.io_req_out, 0);
            @(negedge clk);
            flush_in = 1'b0;
            #1;
            check($sformatf("v%0d_we_off", i), bus.ram_we_out, 0);
            if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rdata_out, vecs[i].exp_rd);
        end

        // ---------------- I/O read, ack in third wait cycle ----------------
        @(negedge clk);
        control_in = c_ldr4;
        result_in  = 16'hFF04;
        @(negedge clk);
        control_in = '0;
        result_in  = '0;
        #1;
        check("io_entry_stall", stall_out, 1);
        check("io_entry_req", bus.io_req_out, 1);
        check("io_entry_bubble", control_out, 0);
        check("io_addr", bus.io_addr_out, 8'h04);
        check("io_we_read", bus.io_we_out, 0);
        n_stall  = int'(stall_out);
        bad_wait = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 3) begin
                bus.io_ack_in   = 1'b1;
                bus.io_rdata_in = 16'h00A5;
            end
            #1;
            n_stall += int'(stall_out);
            if (control_out != '0 || !bus.io_req_out) bad_wait = 1'b1;
        end
        check("io_wait_bubble_req", bad_wait, 0);
        @(negedge clk);
        bus.io_ack_in   = 1'b0;
        bus.io_rdata_in = '0;
        #1;
        check("io_done_ctrl", control_out, c_ldr4);
        check("io_done_stall", stall_out, 0);
        check("io_done_req", bus.io_req_out, 0);
        check("io_stall_cycles", n_stall, 4);
        @(negedge clk);
        #1;
        check("io_rdata", rdata_out, 16'h00A5);
        check("io_no_err", io_err_out, 0);

        // ---------------- I/O read with no ack: timeout ----------------
        @(negedge clk);
        control_in = c_ldr7;
        result_in  = 16'hFF08;
        req_cycles = 0;
        done       = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            control_in = '0;
            result_in  = '0;
            #1;
            if (bus.io_req_out) req_cycles++;
            else                done = 1'b1;
        end
        check("to_req_cycles", req_cycles, 257);
        check("to_done_ctrl", control_out, c_ldr7);
        check("to_err", io_err_out, 1);
        @(negedge clk);
        #1;
        check("to_rdata", rdata_out, 16'hFFFF);
        repeat (3) @(negedge clk);
        #1;
        check("to_err_sticky", io_err_out, 1);

        // ---------------- flush while waiting on an I/O store ----------------
        @(negedge clk);
        control_in    = c_strio;
        result_in     = 16'hFF02;
        store_data_in = 16'h7777;
        @(negedge clk);
        control_in    = '0;
        result_in     = '0;
        store_data_in = '0;
        #1;
        check("fl_entry_req", bus.io_req_out, 1);
        check("fl_io_we", bus.io_we_out, 1);
        check("fl_io_wdata", bus.io_wdata_out, 16'h7777);
        check("fl_ram_we", bus.ram_we_out, 0);
        @(negedge clk);
        flush_in = 1'b1;
        #1;
        check("fl_stall_held", stall_out, 1);
        @(negedge clk);
        flush_in = 1'b0;
        #1;
        check("fl_req_held", bus.io_req_out, 1);
        @(negedge clk);
        bus.io_ack_in = 1'b1;
        #1;
        @(negedge clk);
        bus.io_ack_in = 1'b0;
        #1;
        check("fl_done_bubble", control_out, 0);
        check("fl_done_stall", stall_out, 0);
        check("fl_err_sticky", io_err_out, 1);

        // ---------------- reset in the middle of IO_WAIT ----------------
        @(negedge clk);
        control_in = c_ldr4;
        result_in  = 16'hFF06;
        @(negedge clk);
        control_in = '0;
        result_in  = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("mr_pre_req", bus.io_req_out, 1);
        rst = 1'b0;
        #1;
        check("mr_ctrl", control_out, 0);
        check("mr_result", result_out, 0);
        check("mr_rdata", rdata_out, 0);
        check("mr_stall", stall_out, 0);
        check("mr_req", bus.io_req_out, 0);
        check("mr_err", io_err_out, 0);
        check("mr_ram_addr", bus.ram_addr_out, 0);
        check("mr_io_addr", bus.io_addr_out, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        control_in = c_ldr2;
        result_in  = 16'h0010;
        @(negedge clk);
        control_in = '0;
        result_in  = '0;
        #1;
        check("mr_ldr_ctrl", control_out, c_ldr2);
        check("mr_ldr_stall", stall_out, 0);
        @(negedge clk);
        #1;
        check("mr_ldr_rdata", rdata_out, 16'hBEEF);

        // ---------------- randomized stream ----------------
        for (int i = 0; i < 65536; i++) model_mem[i] = init_val(16'(i));
        for (int i = 0; i < 256; i++) model_io[i] = io_init(8'(i));
        need_new  = 1'b1;
        req_seen  = 0;
        ack_delay = 3;
        pend      = 1'b0;
        for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
        for (int i = 0; i < 60; i++) rand_cycle(1'b0);
        check("rnd_drain_empty", exp_q.size(), 0);
        check("rnd_drain_stall", stall_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
